// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default sizing, pointer type, Gray/binary conversion.
// No logic of its own; functions are purely combinational.
// Used by both the write-side (wptr_full) and read-side (rptr_empty) pointer blocks.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 6;

    // Pointer at the default size: one extra MSB distinguishes full from empty
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

    // Conversions work on a wide word. Callers zero-extend narrower pointers into it
    // and cast the result back. Leading zeros map to leading zeros in both directions,
    // so this holds for any pointer width up to MAX_PTR_W.
    localparam int MAX_PTR_W = 32;
    typedef logic [MAX_PTR_W-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bus of the async FIFO: push request and synced read pointer in; RAM write and flags out.
// Latency is set by the block driving the slave modport (registered flags, combinational wen).
// No handshake inside the bus: the pusher must watch wfull; pushes made while full are dropped.
interface wptr_full_if #(
    parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  wfull;
    logic                  wafull;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  wovf;

    // Pointer/flag block side: consumes pushes, produces RAM write and status
    modport slave (
        input  winc, wq2_rptr,
        output wen, waddr, wptr, wfull, wafull, wcount, wovf
    );

    // Producer side: issues pushes and feeds back the synchronized read pointer
    modport master (
        output winc, wq2_rptr,
        input  wen, waddr, wptr, wfull, wafull, wcount, wovf
    );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer, RAM write strobe, and full/almost-full/occupancy/overflow flags for the async FIFO.
// wen is combinational in the push cycle; pointers and flags are registered and show the post-push state one edge later.
// A push while wfull is high is dropped and sets the sticky wovf; flags lean toward full because wq2_rptr lags.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_MARGIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    wptr_full_if.slave bus
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH:0] wbin_q,   wbin_d;
    logic [ADDR_WIDTH:0] wgray_q,  wgray_d;
    logic [ADDR_WIDTH:0] wcount_q, wcount_d;
    logic                wfull_q,  wfull_d;
    logic                wafull_q, wafull_d;
    logic                wovf_q,   wovf_d;

    logic                push;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] full_gray;

    // Next pointer and flags. They use the post-push pointer and the freshly sampled read pointer together.
    always_comb begin
        push      = 1'b0;
        wbin_d    = wbin_q;
        wgray_d   = wgray_q;
        rbin      = '0;
        full_gray = '0;
        wcount_d  = wcount_q;
        wfull_d   = wfull_q;
        wafull_d  = wafull_q;
        wovf_d    = wovf_q;

        push    = bus.winc & ~wfull_q;
        wbin_d  = wbin_q + PW'(push);
        wgray_d = PW'(bin2gray(word_t'(wbin_d)));

        // Full in Gray terms: the write pointer is one lap ahead, so the top two bits are inverted
        full_gray = {~bus.wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], bus.wq2_rptr[ADDR_WIDTH-2:0]};
        wfull_d   = (wgray_d == full_gray);

        // Modulo subtraction in PW bits gives 0..DEPTH as long as the pointers are legal
        rbin     = PW'(gray2bin(word_t'(bus.wq2_rptr)));
        wcount_d = wbin_d - rbin;
        wafull_d = (wcount_d >= PW'(DEPTH - AFULL_MARGIN));

        wovf_d = wovf_q | (bus.winc & wfull_q);
    end

    // State registers, cleared asynchronously so every output drops as soon as reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign bus.wen    = push;
    assign bus.waddr  = wbin_q[ADDR_WIDTH-1:0];
    assign bus.wptr   = wgray_q;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wcount = wcount_q;
    assign bus.wovf   = wovf_q;

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. Accepts push requests, maintains the binary and Gray write pointers, drives the write address and enable to the dual-port RAM, and publishes the Gray write pointer to the read-domain synchronizer. Compares against the read pointer already synchronized into the write clock domain to produce registered full, almost-full, occupancy and overflow indications.

## Interface
- ADDR_WIDTH, 6, RAM address width; depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- AFULL_MARGIN, 4, wafull asserts when occupancy >= DEPTH - AFULL_MARGIN; legal range 1..DEPTH-1

- clk  in  1  write-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- winc  in  1  push request for this cycle
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized to clk
- wen  out  1  RAM write enable, combinational: winc & ~wfull
- waddr  out  ADDR_WIDTH  RAM write address, low bits of the binary write pointer (registered)
- wptr  out  ADDR_WIDTH+1  Gray write pointer (registered) to the read-domain synchronizer
- wfull  out  1  FIFO full (registered)
- wafull  out  1  almost full (registered)
- wcount  out  ADDR_WIDTH+1  occupancy as seen by the write domain, 0..DEPTH (registered)
- wovf  out  1  sticky overflow: push attempted while full

## Operation
- Reset: wbin, wptr, waddr, wcount = 0; wfull, wafull, wovf = 0. All take effect immediately on rst_n low, held until the first clk edge after release.
- Push accepted when winc & ~wfull. wen equals the accepted push in the same cycle, with waddr as the write address.
- Next binary pointer: wbin_next = wbin + accepted, modulo 2**(ADDR_WIDTH+1), wrapping silently.
- Gray conversion: wgray_next = (wbin_next >> 1) ^ wbin_next. wptr is registered from wgray_next, so exactly one bit changes per accepted push, including at wrap.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
- Occupancy: rbin = gray2bin(wq2_rptr). wcount <= wbin_next - rbin, computed in ADDR_WIDTH+1 bits, with unsigned wrap.
- wafull <= (wbin_next - rbin) >= DEPTH - AFULL_MARGIN.
- Overflow: winc & wfull sets wovf on the next edge. The push is dropped and pointers are unchanged. wovf clears only on reset.
- Flags are conservative. wq2_rptr lags the true read pointer by the synchronizer depth, so wfull, wafull and wcount may overstate occupancy but never understate it.
- wfull deasserts in the cycle after a changed wq2_rptr is sampled, provided there is no simultaneous accepted push.

## Timing
- Accepted push at edge N: wptr, waddr and wcount updated after edge N. wfull/wafull reflect the post-push state after edge N, with no extra cycle.
- Push of the DEPTH-th entry: wfull is high after that edge. A winc in the next cycle gives wen = 0.
- Simultaneous push and wq2_rptr change in the same cycle: both are used in the next-state computation, and the flags reflect both.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. Pointers restart at 0. The read domain must be reset concurrently; this is an integration requirement.
- wq2_rptr is sampled only at clk edges, is assumed stable and Gray-coded, and is not checked.

## Structure
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized by width
  - localparam defaults for ADDR_WIDTH
  - the ptr_t typedef, logic [ADDR_WIDTH:0]
- The read-side counterpart, rptr_empty, uses the same package.
- No sub-module. One always_ff for state, one always_comb for next-state and flag logic.

## Test plan
- Reset, then 64 pushes with wq2_rptr = 0:
  - wcount steps 1..64
  - wafull rises after the push that makes wcount = 60
  - wfull rises after push 64
  - wptr sequence matches bin2gray(0..64); final wptr = 7'b1100000
- Full, then winc held for 3 cycles: wen = 0, pointers frozen, wovf = 1 from the next cycle and remaining 1.
- Full, then wq2_rptr changes 0 -> 1 (Gray): wfull = 0 and wcount = 63 one cycle later. One push then refills: wfull = 1, wcount = 64.
- Wrap: drive wq2_rptr to track pointers through 200 pushes. wptr passes from 7'b1000000 back to 7'b0000000 with a single bit change per push, and waddr wraps 63 -> 0.
- Simultaneous push and wq2_rptr advance at wcount = 64 minus 1: wcount stays 63 and wfull stays 0.
- Assert rst_n low mid-burst, asynchronously between edges: all outputs read 0 before the next edge; wovf cleared.
